// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a 32-byte register window.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic          hit;
  logic [1:0]    sel;
  logic          push_req, push_ok, pop, clr_req, div_wr, ovf_set;
  logic          full, empty;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic [15:0]   div_reg, div_next;

  state_t        state_reg, state_next;
  logic [15:0]   timer_reg, timer_next, div_lat_reg, div_lat_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
  assign sel      = addr[4:3];
  assign push_req = wr_en & hit & (sel == 2'd0) & wmask[0];
  assign clr_req  = wr_en & hit & (sel == 2'd1) & wmask[0] & wdata[3];
  assign div_wr   = wr_en & hit & (sel == 2'd2);

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  for (genvar gi = 0; gi < 2; gi++) begin : g_div_lane
    assign div_next[gi*8 +: 8] = (div_wr && wmask[gi]) ? wdata[gi*8 +: 8] : div_reg[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      div_reg    <= DIV_RESET;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
      ovf_reg   <= ovf_set | (ovf_reg & ~clr_req);
      div_reg   <= div_next;
    end
  end

  // Each bit lasts div_lat_reg+1 cycles; the timer counts down to zero.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg - 16'd1;
    div_lat_next = div_lat_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        timer_next = timer_reg;
        tx_next    = 1'b1;
        pop        = ~empty;
      end
      ST_START: begin
        if (timer_reg == '0) begin
          state_next   = ST_DATA;
          timer_next   = div_lat_reg;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (timer_reg == '0) begin
          timer_next = div_lat_reg;
          if (bit_idx_reg == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_next = ST_PARITY;
            tx_next    = ^shift_reg;
`else
            state_next = ST_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[bit_idx_reg + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        if (timer_reg == '0) begin
          state_next = ST_STOP;
          timer_next = div_lat_reg;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (timer_reg == '0) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Frame start: the divisor is captured here so mid-frame writes wait for the next frame.
    if (pop) begin
      state_next   = ST_START;
      shift_next   = mem[rd_ptr_reg];
      div_lat_next = div_reg;
      timer_next   = div_reg;
      tx_next      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      div_lat_reg <= DIV_RESET;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      div_lat_reg <= div_lat_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != ST_IDLE) | ~empty;

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (sel)
        2'd1:    rdata = {48'h0, 8'(count_reg), 3'b000, PARITY_EN, ovf_reg, empty, full, tx_busy};
        2'd2:    rdata = {48'h0, div_reg};
        default: rdata = '0;
      endcase
    end
  end

  // Address offset bits and upper store lanes are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[2:0], wdata[63:16], wmask[7:2]};

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that acts as a responder on the processor's data-memory bus (addr/wr_en/wdata/wmask/rdata). It sits beside the data memory; the system decodes a 32-byte window at BASE_ADDR to it. Stores are queued as bytes in a FIFO and serialized 8N1, LSB first, on tx. Loads from the window return status and divisor registers.

Parameters:
BASE_ADDR, 32'h0000_1000, byte base of register window; bits [4:0] must be 0
FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2
DIV_RESET, 16'd15, reset divisor; bit period = DIV+1 clk cycles

Ports:
clk  input  1  system clock, all state on rising edge
nrst  input  1  synchronous active-low reset
addr  input  32  byte address from processor
wr_en  input  1  store strobe, sampled on clk rising edge
wdata  input  64  store data, doubleword-aligned lanes
wmask  input  8  byte-lane enables for wdata
rdata  output  64  load data, combinational from addr
tx  output  1  serial line, registered, idles high
tx_busy  output  1  high while a frame is on the line or FIFO non-empty

Behaviour:
- Hit = addr[31:5]==BASE_ADDR[31:5]. Register select = addr[4:3]. addr[2:0] ignored.
- Map: 0 TXDATA (W), 1 STATUS (R/W1C), 2 DIVISOR (R/W), 3 reserved (reads 0, writes ignored).
- Reads: rdata combinational, same cycle as addr. No hit or reserved/TXDATA offset -> 64'h0.
- STATUS read: [0] tx_busy, [1] fifo full, [2] fifo empty, [3] overflow (sticky), [15:8] fifo count (zero-extended); other bits 0.
- Write TXDATA with wr_en=1, hit, wmask[0]=1: push wdata[7:0]. wmask[0]=0 -> no push. Other lanes ignored.
- Push when full and no pop in the same cycle: byte dropped, overflow set. Push and pop in the same cycle when full: accepted, count unchanged.
- STATUS write with wmask[0]=1 and wdata[3]=1 clears overflow. Set-by-overflow and clear in the same cycle: set wins.
- DIVISOR write: wmask[0] -> [7:0], wmask[1] -> [15:8]. Divisor is latched into the bit timer only at frame start (IDLE->START or STOP->START), so a mid-frame write does not disturb the current frame. DIV=0 gives a 1-cycle bit period.
- Reset (nrst=0 at an edge): tx=1, FIFO empty, count=0, overflow=0, divisor=DIV_RESET, FSM=IDLE, tx_busy=0. Reset mid-frame aborts the frame immediately; tx returns high after that edge.
- FSM states:
  - IDLE: tx=1. FIFO non-empty -> pop head into shift register, load bit counter, go to START.
  - START: tx=0 for DIV+1 cycles -> DATA.
  - DATA: 8 bits, LSB first, each held DIV+1 cycles -> STOP.
  - STOP: tx=1 for DIV+1 cycles. If FIFO non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- Latency: store sampled at edge E0. FSM pops at E1. tx falls after E1. A frame lasts 10*(DIV+1) cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is a separate register with width log2(FIFO_DEPTH)+1.
- tx_busy = (FSM!=IDLE) | ~empty.

Optional Feature:
MMIO_UART_TX_PARITY_EN:
- Defined: a PARITY state between DATA and STOP transmits an even-parity bit (XOR of the 8 data bits) for DIV+1 cycles. A frame lasts 11*(DIV+1) cycles. STATUS[4] reads 1.
- Undefined: no PARITY state, 10-bit frame, STATUS[4] reads 0.

Test Plan:
- Reset, then read BASE+0x8 and BASE+0x10 -> STATUS=64'h4 (empty), DIVISOR=64'hF; tx=1, tx_busy=0.
- Write DIVISOR=3, then store 0xA5 to BASE+0x0 at E0 -> tx low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; 40-cycle frame; tx_busy drops after stop.
- With DIV=0, store 0x01, 0x02, 0x03 on consecutive cycles -> three 10-cycle frames back-to-back, no idle between stop and start; STATUS count reads 2, 1, 0 as each pops.
- With DIV=15, store 10 bytes rapidly (FIFO_DEPTH=8) -> first pops immediately, 8 queued, 10th dropped; STATUS[1]=1, STATUS[3]=1; write STATUS with wdata=8 -> overflow clears.
- Store to BASE+0x20 and with wmask=8'hFE to BASE+0x0 -> no push, tx stays 1. Read of an unmapped address -> rdata=0.
- Assert nrst mid-DATA -> tx=1, count=0 next cycle; then store 0x55 -> clean full frame. With MMIO_UART_TX_PARITY_EN, 0x07 -> parity bit 1, 11-bit frame.
